// File: rtl/inst_mem_arbiter_if.sv
// Loader-side bus of the instruction-memory arbiter: session request,
// write strobe/address/data, and grant/ack/abort/count status back to the loader.
interface inst_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
);
   logic              i_ld_req;
   logic              i_ld_we;
   logic [ADDR_W-1:0] i_ld_addr;
   logic [DATA_W-1:0] i_ld_data;
   logic              o_ld_gnt;
   logic              o_ld_ack;
   logic              o_ld_err;
   logic [CNT_W-1:0]  o_ld_count;

   modport master (
      output i_ld_req, i_ld_we, i_ld_addr, i_ld_data,
      input  o_ld_gnt, o_ld_ack, o_ld_err, o_ld_count
   );

   modport slave (
      input  i_ld_req, i_ld_we, i_ld_addr, i_ld_data,
      output o_ld_gnt, o_ld_ack, o_ld_err, o_ld_count
   );
endinterface

// File: rtl/inst_mem_arbiter.sv
// Shares the instruction-memory port between fetch and a program loader, holding then flushing IF/ID.
// Optional macro LOADER_PC_RESTART_EN adds o_pc_restart, pulsed on a normally ended session.
module inst_mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LD_TIMEOUT = 256,
   parameter int CNT_W      = 16
) (
   input  logic                 i_Clk,
   input  logic                 i_reset,
   input  logic [ADDR_W-1:0]    i_pc_addr,
   input  logic [1:0]           i_ex_hold_flag,
   inst_mem_arbiter_if.slave    ld,
   output logic [ADDR_W-1:0]    o_mem_r_addr,
   output logic                 o_mem_we,
   output logic [ADDR_W-1:0]    o_mem_w_addr,
   output logic [DATA_W-1:0]    o_mem_w_data,
   output logic [1:0]           o_hold_flag,
`ifdef LOADER_PC_RESTART_EN
   output logic                 o_pc_restart,
`endif
   output logic                 o_busy
);
   localparam int IDLE_W = (LD_TIMEOUT > 2) ? $clog2(LD_TIMEOUT) : 1;
   localparam logic [1:0] HOLD_STALL = 2'b01;
   localparam logic [1:0] HOLD_FLUSH = 2'b10;

   typedef enum logic [1:0] {FETCH, DRAIN, LOAD, RELEASE} state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] frozen_addr_reg;
   logic [IDLE_W-1:0] idle_reg, idle_next;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic              ack_reg, ack_next;
   logic              err_reg, err_next;
   logic              armed_reg, armed_next;
   logic              capture;

   always_comb begin
      state_next  = state_reg;
      idle_next   = idle_reg;
      count_next  = count_reg;
      ack_next    = 1'b0;
      err_next    = 1'b0;
      armed_next  = armed_reg;
      capture     = 1'b0;
      o_hold_flag = i_ex_hold_flag;
      o_mem_r_addr = i_pc_addr;
      // A timed-out loader must drop its request before it may own memory again
      if (!ld.i_ld_req)
         armed_next = 1'b1;
      case (state_reg)
         FETCH: begin
            if (ld.i_ld_req && armed_reg) begin
               state_next = DRAIN;
               count_next = '0;
               capture    = 1'b1;
            end
         end
         DRAIN: begin
            o_hold_flag  = HOLD_STALL;
            o_mem_r_addr = frozen_addr_reg;
            idle_next    = '0;
            state_next   = LOAD;
         end
         LOAD: begin
            o_hold_flag  = HOLD_STALL;
            o_mem_r_addr = frozen_addr_reg;
            if (!ld.i_ld_req) begin
               state_next = RELEASE;
            end else if (ld.i_ld_we) begin
               ack_next  = 1'b1;
               idle_next = '0;
               if (count_reg != '1)
                  count_next = count_reg + 1'b1;
            end else if (idle_reg == IDLE_W'(LD_TIMEOUT - 1)) begin
               err_next   = 1'b1;
               armed_next = 1'b0;
               state_next = RELEASE;
            end else begin
               idle_next = idle_reg + 1'b1;
            end
         end
         RELEASE: begin
            o_hold_flag = HOLD_FLUSH;
            state_next  = FETCH;
         end
         default: state_next = FETCH;
      endcase
   end

   always_ff @(posedge i_Clk or posedge i_reset) begin
      if (i_reset) begin
         state_reg       <= FETCH;
         frozen_addr_reg <= '0;
         idle_reg        <= '0;
         count_reg       <= '0;
         ack_reg         <= 1'b0;
         err_reg         <= 1'b0;
         armed_reg       <= 1'b1;
      end else begin
         state_reg <= state_next;
         if (capture)
            frozen_addr_reg <= i_pc_addr;
         idle_reg  <= idle_next;
         count_reg <= count_next;
         ack_reg   <= ack_next;
         err_reg   <= err_next;
         armed_reg <= armed_next;
      end
   end

   // Write strobe is gated by reset so a write in flight dies the moment reset rises
   assign o_mem_we     = (state_reg == LOAD) && ld.i_ld_we && ld.i_ld_req && !i_reset;
   assign o_mem_w_addr = (state_reg == LOAD) ? ld.i_ld_addr : '0;
   assign o_mem_w_data = (state_reg == LOAD) ? ld.i_ld_data : '0;
   assign o_busy       = (state_reg != FETCH);

   assign ld.o_ld_gnt   = (state_reg == LOAD);
   assign ld.o_ld_ack   = ack_reg;
   assign ld.o_ld_err   = err_reg;
   assign ld.o_ld_count = count_reg;

`ifdef LOADER_PC_RESTART_EN
   // armed_reg is low during RELEASE only when the session was aborted by timeout
   assign o_pc_restart = (state_reg == RELEASE) && armed_reg;
`endif
endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Randomized self-checking bench for inst_mem_arbiter; expectations follow the session
// timeline (request, drain, load, release) rather than the RTL's state machine.
module tb_inst_mem_arbiter;
   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int LD_TIMEOUT = 4;
   localparam int CNT_W      = 3;
   localparam int CNT_MAX    = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [ADDR_W-1:0] pc_addr;
   logic [1:0]        ex_hold;
   logic [ADDR_W-1:0] mem_r_addr;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_w_addr;
   logic [DATA_W-1:0] mem_w_data;
   logic [1:0]        hold_flag;
   logic              busy;
`ifdef LOADER_PC_RESTART_EN
   logic              pc_restart;
`endif

   int total = 0;
   int bad   = 0;

   inst_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

   inst_mem_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LD_TIMEOUT(LD_TIMEOUT), .CNT_W(CNT_W)
   ) dut (
      .i_Clk          (clk),
      .i_reset        (rst),
      .i_pc_addr      (pc_addr),
      .i_ex_hold_flag (ex_hold),
      .ld             (bus),
      .o_mem_r_addr   (mem_r_addr),
      .o_mem_we       (mem_we),
      .o_mem_w_addr   (mem_w_addr),
      .o_mem_w_data   (mem_w_data),
      .o_hold_flag    (hold_flag),
`ifdef LOADER_PC_RESTART_EN
      .o_pc_restart   (pc_restart),
`endif
      .o_busy         (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] rand_ex();
      return 2'($urandom_range(0, 2));
   endfunction

   function automatic logic [CNT_W-1:0] sat(input int n);
      return CNT_W'((n > CNT_MAX) ? CNT_MAX : n);
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      ex_hold = 2'b01;
      pc_addr = 32'h100;
      @(negedge clk);
      total++; if (bus.o_ld_gnt !== 1'b0) begin bad++; $display("FAIL rst_gnt got=%0b exp=0", bus.o_ld_gnt); end
      total++; if (bus.o_ld_ack !== 1'b0) begin bad++; $display("FAIL rst_ack got=%0b exp=0", bus.o_ld_ack); end
      total++; if (bus.o_ld_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0b exp=0", bus.o_ld_err); end
      total++; if (bus.o_ld_count !== '0) begin bad++; $display("FAIL rst_count got=%0d exp=0", bus.o_ld_count); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b exp=0", busy); end
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%0b exp=0", mem_we); end
      total++; if (hold_flag !== 2'b01) begin bad++; $display("FAIL rst_hold got=%0d exp=1", hold_flag); end
      next_cycle();
      rst = 1'b0;
      $display("reset released");
   endtask

   task automatic test_fetch();
      logic [ADDR_W-1:0] pcs [6];
      logic [1:0]        ex;
      pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
      for (int i = 3; i < 6; i++) pcs[i] = $urandom;
      for (int i = 0; i < 6; i++) begin
         ex = (i < 3) ? 2'b01 : rand_ex();
         pc_addr = pcs[i];
         ex_hold = ex;
         @(negedge clk);
         total++; if (mem_r_addr !== pcs[i]) begin bad++; $display("FAIL fetch_raddr got=%h exp=%h", mem_r_addr, pcs[i]); end
         total++; if (hold_flag !== ex) begin bad++; $display("FAIL fetch_hold got=%0d exp=%0d", hold_flag, ex); end
         total++; if (mem_we !== 1'b0 || mem_w_addr !== '0 || mem_w_data !== '0) begin bad++; $display("FAIL fetch_wport got=%0b/%h/%h exp=0/0/0", mem_we, mem_w_addr, mem_w_data); end
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL fetch_busy got=%0b exp=0", busy); end
         $display("fetch pc=%h ex=%0d", pcs[i], ex);
         next_cycle();
      end
   endtask

   task automatic test_load_session(input int n_writes, input bit we_on_drop);
      logic [ADDR_W-1:0] pc_cap;
      logic [1:0]        ex;
      logic [DATA_W-1:0] wdata;
      bit                prev_wr;
      bit                wr;
      int                done;
      int                gap;
      prev_wr = 1'b0;
      done    = 0;
      ex = rand_ex(); ex_hold = ex; pc_addr = $urandom;
      bus.i_ld_req = 1'b1; bus.i_ld_we = 1'b0;
      @(negedge clk);
      total++; if (hold_flag !== ex) begin bad++; $display("FAIL req_hold got=%0d exp=%0d", hold_flag, ex); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL req_busy got=%0b exp=0", busy); end
      pc_cap = pc_addr;
      next_cycle();
      ex_hold = rand_ex(); pc_addr = $urandom;
      @(negedge clk);
      total++; if (hold_flag !== 2'b01) begin bad++; $display("FAIL drain_hold got=%0d exp=1", hold_flag); end
      total++; if (bus.o_ld_gnt !== 1'b0) begin bad++; $display("FAIL drain_gnt got=%0b exp=0", bus.o_ld_gnt); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL drain_busy got=%0b exp=1", busy); end
      total++; if (mem_r_addr !== pc_cap) begin bad++; $display("FAIL drain_raddr got=%h exp=%h", mem_r_addr, pc_cap); end
      total++; if (bus.o_ld_count !== '0) begin bad++; $display("FAIL drain_count got=%0d exp=0", bus.o_ld_count); end
      next_cycle();
      for (int w = 0; w < n_writes; w++) begin
         gap = $urandom_range(0, LD_TIMEOUT - 2);
         for (int g = 0; g <= gap; g++) begin
            wr = (g == gap);
            wdata = $urandom;
            ex_hold = rand_ex(); pc_addr = $urandom;
            bus.i_ld_we = wr; bus.i_ld_addr = ADDR_W'(w * 4); bus.i_ld_data = wdata;
            @(negedge clk);
            total++; if (bus.o_ld_gnt !== 1'b1) begin bad++; $display("FAIL load_gnt got=%0b exp=1", bus.o_ld_gnt); end
            total++; if (hold_flag !== 2'b01) begin bad++; $display("FAIL load_hold got=%0d exp=1", hold_flag); end
            total++; if (mem_r_addr !== pc_cap) begin bad++; $display("FAIL load_raddr got=%h exp=%h", mem_r_addr, pc_cap); end
            total++; if (mem_we !== wr) begin bad++; $display("FAIL load_we got=%0b exp=%0b", mem_we, wr); end
            total++; if (bus.o_ld_ack !== prev_wr) begin bad++; $display("FAIL load_ack got=%0b exp=%0b", bus.o_ld_ack, prev_wr); end
            total++; if (bus.o_ld_count !== sat(done)) begin bad++; $display("FAIL load_count got=%0d exp=%0d", bus.o_ld_count, sat(done)); end
            if (wr) begin
               total++; if (mem_w_addr !== ADDR_W'(w * 4) || mem_w_data !== wdata) begin bad++; $display("FAIL load_wport got=%h/%h exp=%h/%h", mem_w_addr, mem_w_data, w * 4, wdata); end
               done++;
            end
            prev_wr = wr;
            next_cycle();
         end
      end
      bus.i_ld_req = 1'b0; bus.i_ld_we = we_on_drop; bus.i_ld_addr = $urandom;
      @(negedge clk);
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL drop_we got=%0b exp=0", mem_we); end
      total++; if (bus.o_ld_ack !== prev_wr) begin bad++; $display("FAIL drop_ack got=%0b exp=%0b", bus.o_ld_ack, prev_wr); end
      next_cycle();
      bus.i_ld_we = 1'b0; ex_hold = rand_ex(); pc_addr = $urandom;
      @(negedge clk);
      total++; if (hold_flag !== 2'b10) begin bad++; $display("FAIL rel_hold got=%0d exp=2", hold_flag); end
      total++; if (bus.o_ld_gnt !== 1'b0) begin bad++; $display("FAIL rel_gnt got=%0b exp=0", bus.o_ld_gnt); end
      total++; if (bus.o_ld_ack !== 1'b0) begin bad++; $display("FAIL rel_ack got=%0b exp=0", bus.o_ld_ack); end
      total++; if (bus.o_ld_err !== 1'b0) begin bad++; $display("FAIL rel_err got=%0b exp=0", bus.o_ld_err); end
      total++; if (mem_r_addr !== pc_addr) begin bad++; $display("FAIL rel_raddr got=%h exp=%h", mem_r_addr, pc_addr); end
`ifdef LOADER_PC_RESTART_EN
      total++; if (pc_restart !== 1'b1) begin bad++; $display("FAIL rel_restart got=%0b exp=1", pc_restart); end
`endif
      next_cycle();
      ex = rand_ex(); ex_hold = ex;
      @(negedge clk);
      total++; if (hold_flag !== ex) begin bad++; $display("FAIL post_hold got=%0d exp=%0d", hold_flag, ex); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_busy got=%0b exp=0", busy); end
      total++; if (bus.o_ld_count !== sat(n_writes)) begin bad++; $display("FAIL post_count got=%0d exp=%0d", bus.o_ld_count, sat(n_writes)); end
`ifdef LOADER_PC_RESTART_EN
      total++; if (pc_restart !== 1'b0) begin bad++; $display("FAIL post_restart got=%0b exp=0", pc_restart); end
`endif
      $display("session writes=%0d we_on_drop=%0b count=%0d", n_writes, we_on_drop, bus.o_ld_count);
      next_cycle();
   endtask

   task automatic test_flush_coincide();
      bus.i_ld_req = 1'b1; bus.i_ld_we = 1'b0; ex_hold = 2'b10;
      @(negedge clk);
      total++; if (hold_flag !== 2'b10) begin bad++; $display("FAIL coin_hold got=%0d exp=2", hold_flag); end
      next_cycle();
      ex_hold = 2'b00;
      @(negedge clk);
      total++; if (hold_flag !== 2'b01) begin bad++; $display("FAIL coin_drain got=%0d exp=1", hold_flag); end
      bus.i_ld_req = 1'b0;
      next_cycle(); next_cycle(); next_cycle();
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL coin_end_busy got=%0b exp=0", busy); end
      $display("flush with request checked");
      next_cycle();
   endtask

   task automatic test_timeout();
      bit         pre_wr;
      logic [1:0] ex;
      pre_wr = 1'($urandom_range(0, 1));
      bus.i_ld_req = 1'b1; bus.i_ld_we = 1'b0;
      next_cycle();
      next_cycle();
      if (pre_wr) begin
         bus.i_ld_we = 1'b1; bus.i_ld_addr = 32'h40; bus.i_ld_data = $urandom;
         next_cycle();
         bus.i_ld_we = 1'b0;
      end
      for (int i = 0; i < LD_TIMEOUT; i++) begin
         @(negedge clk);
         total++; if (bus.o_ld_gnt !== 1'b1 || bus.o_ld_err !== 1'b0) begin bad++; $display("FAIL to_idle%0d got=%0b/%0b exp=1/0", i, bus.o_ld_gnt, bus.o_ld_err); end
         next_cycle();
      end
      @(negedge clk);
      total++; if (bus.o_ld_err !== 1'b1) begin bad++; $display("FAIL to_err got=%0b exp=1", bus.o_ld_err); end
      total++; if (hold_flag !== 2'b10) begin bad++; $display("FAIL to_hold got=%0d exp=2", hold_flag); end
      total++; if (bus.o_ld_gnt !== 1'b0) begin bad++; $display("FAIL to_gnt got=%0b exp=0", bus.o_ld_gnt); end
      total++; if (bus.o_ld_count !== sat(int'(pre_wr))) begin bad++; $display("FAIL to_count got=%0d exp=%0d", bus.o_ld_count, pre_wr); end
`ifdef LOADER_PC_RESTART_EN
      total++; if (pc_restart !== 1'b0) begin bad++; $display("FAIL to_restart got=%0b exp=0", pc_restart); end
`endif
      next_cycle();
      for (int i = 0; i < 3; i++) begin
         ex = rand_ex(); ex_hold = ex;
         @(negedge clk);
         total++; if (busy !== 1'b0 || hold_flag !== ex) begin bad++; $display("FAIL to_rearm%0d got=%0b/%0d exp=0/%0d", i, busy, hold_flag, ex); end
         total++; if (bus.o_ld_err !== 1'b0) begin bad++; $display("FAIL to_err_pulse got=%0b exp=0", bus.o_ld_err); end
         next_cycle();
      end
      bus.i_ld_req = 1'b0;
      next_cycle();
      bus.i_ld_req = 1'b1;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL to_req_busy got=%0b exp=0", busy); end
      next_cycle();
      @(negedge clk);
      total++; if (busy !== 1'b1 || hold_flag !== 2'b01) begin bad++; $display("FAIL to_redrain got=%0b/%0d exp=1/1", busy, hold_flag); end
      bus.i_ld_req = 1'b0;
      next_cycle(); next_cycle(); next_cycle();
      $display("timeout session pre_write=%0b", pre_wr);
   endtask

   task automatic test_back_to_back();
      for (int s = 0; s < 4; s++)
         test_load_session($urandom_range(1, 5), 1'($urandom_range(0, 1)));
      test_load_session(CNT_MAX + 2, 1'b1);
   endtask

   task automatic test_reset_mid_load();
      bus.i_ld_req = 1'b1; bus.i_ld_we = 1'b0;
      next_cycle();
      next_cycle();
      bus.i_ld_we = 1'b1; bus.i_ld_addr = 32'h10; bus.i_ld_data = $urandom;
      next_cycle();
      ex_hold = rand_ex();
      @(negedge clk);
      total++; if (mem_we !== 1'b1 || bus.o_ld_count !== 3'd1) begin bad++; $display("FAIL mid_pre got=%0b/%0d exp=1/1", mem_we, bus.o_ld_count); end
      #1 rst = 1'b1;
      #1;
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL mid_we got=%0b exp=0", mem_we); end
      total++; if (bus.o_ld_gnt !== 1'b0) begin bad++; $display("FAIL mid_gnt got=%0b exp=0", bus.o_ld_gnt); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%0b exp=0", busy); end
      total++; if (bus.o_ld_count !== '0) begin bad++; $display("FAIL mid_count got=%0d exp=0", bus.o_ld_count); end
      total++; if (hold_flag !== ex_hold) begin bad++; $display("FAIL mid_hold got=%0d exp=%0d", hold_flag, ex_hold); end
      bus.i_ld_req = 1'b0; bus.i_ld_we = 1'b0;
      next_cycle();
      rst = 1'b0;
      $display("reset during load checked");
      next_cycle();
   endtask

   initial begin
      bus.i_ld_req  = 1'b0;
      bus.i_ld_we   = 1'b0;
      bus.i_ld_addr = '0;
      bus.i_ld_data = '0;
      pc_addr       = '0;
      ex_hold       = 2'b00;
      test_reset();
      test_fetch();
      test_load_session(3, 1'b1);
      test_flush_coincide();
      test_timeout();
      test_back_to_back();
      test_reset_mid_load();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "bench did not finish");
   end
endmodule

// File: doc/inst_mem_arbiter.md
Name: inst_mem_arbiter

Overview:
Owns the instruction-memory port and shares it between the fetch path (read, PC-driven) and a program loader (write, e.g. UART/debug bootloader).
While the loader owns memory, the block holds the pipeline. On release it flushes the IF/ID buffer so no stale instruction reaches decode.
It sits between the PC register, the ex-stage hold logic, the loader and inst_rom. Its hold output replaces the ex hold flag at the IF/ID buffer.

Parameters:
ADDR_W, 32, instruction address width
DATA_W, 32, instruction word width
LD_TIMEOUT, 256, idle cycles in LOAD (i_ld_req high, i_ld_we low) before abort; must be >= 2
CNT_W, 16, width of loaded-word counter

Ports:
i_Clk  in  1  clock
i_reset  in  1  reset, asynchronous, active-high
i_pc_addr  in  ADDR_W  fetch address from PC
i_ex_hold_flag  in  2  hold flag from ex (00 run, 01 IF_ID_hold, 10 IF_ID_flush)
i_ld_req  in  1  loader requests memory ownership; level, held for whole session
i_ld_we  in  1  loader write strobe, valid only while o_ld_gnt=1
i_ld_addr  in  ADDR_W  loader write address
i_ld_data  in  DATA_W  loader write data
o_ld_gnt  out  1  loader owns memory
o_ld_ack  out  1  one-cycle pulse, write accepted (registered, 1 cycle after i_ld_we)
o_ld_err  out  1  one-cycle pulse, session aborted by timeout
o_ld_count  out  CNT_W  words written in current/last session, saturating
o_mem_r_addr  out  ADDR_W  read address to inst_rom
o_mem_we  out  1  write enable to inst_rom
o_mem_w_addr  out  ADDR_W  write address to inst_rom
o_mem_w_data  out  DATA_W  write data to inst_rom
o_hold_flag  out  2  hold flag to IF/ID buffer (same encoding as i_ex_hold_flag)
o_busy  out  1  state != FETCH

Behaviour:
- Reset (async): state FETCH; o_ld_gnt, o_ld_ack, o_ld_err, o_ld_count, o_busy = 0. o_mem_we forced 0 immediately, including mid-write. o_hold_flag follows i_ex_hold_flag.
- FSM states: FETCH, DRAIN, LOAD, RELEASE.
- FETCH:
  - o_mem_r_addr = i_pc_addr; o_hold_flag = i_ex_hold_flag (combinational pass-through).
  - i_ld_req=1 -> DRAIN; o_ld_count cleared on this transition.
  - If ex flush coincides with request: flush wins that cycle, transition still taken.
- DRAIN: exactly 1 cycle. o_hold_flag=01; lets the in-flight ROM read retire. Then -> LOAD.
- LOAD:
  - o_ld_gnt=1, o_hold_flag=01 regardless of i_ex_hold_flag; o_mem_r_addr frozen at the value captured on entry to DRAIN.
  - o_mem_we = i_ld_we & i_ld_req (combinational); o_mem_w_addr/o_mem_w_data = i_ld_addr/i_ld_data.
  - Each write: o_ld_ack pulses next cycle; o_ld_count +1, saturating at all-ones.
  - Idle counter increments on cycles with i_ld_we=0, clears on any write.
  - Idle counter reaches LD_TIMEOUT -> pulse o_ld_err, -> RELEASE.
  - i_ld_req=0 -> RELEASE; a same-cycle i_ld_we is ignored (no write, no ack).
- RELEASE: 1 cycle. o_ld_gnt=0, o_hold_flag=10 (flush), o_mem_we=0, o_mem_r_addr = i_pc_addr. Then -> FETCH.
  - i_ld_req still high (timeout abort): back to FETCH anyway. A new session starts only after i_ld_req is seen low for >= 1 cycle (re-arm flag).
- Outside LOAD: o_mem_we=0; o_mem_w_addr/o_mem_w_data=0.
- o_ld_count holds its value after the session until the next DRAIN entry.

Optional Feature:
LOADER_PC_RESTART_EN
- Defined: adds output o_pc_restart (1 bit), a one-cycle pulse during RELEASE, telling PC to restart at address 0. Only asserted when the session ended normally, not on timeout.
- Undefined: port absent; PC resumes from its held value after the flush.

Test Plan:
- Reset mid-LOAD with i_ld_we=1 -> o_mem_we=0 and o_ld_gnt=0 same cycle; state FETCH; o_ld_count=0.
- FETCH, ex flag 01, no request -> o_hold_flag=01; o_mem_r_addr tracks i_pc_addr 0x0,0x4,0x8.
- i_ld_req rises at cycle N -> DRAIN at N+1 (hold 01), o_ld_gnt=1 at N+2. Write 3 words to 0x0/0x4/0x8 -> 3 o_mem_we pulses with matching addr/data, 3 acks each one cycle later, o_ld_count=3.
- i_ld_req drops -> one cycle o_hold_flag=10, then pass-through; with LOADER_PC_RESTART_EN, o_pc_restart pulses in that cycle.
- LD_TIMEOUT=4, grant then no writes -> o_ld_err pulse after 4 idle cycles, flush cycle. Keep i_ld_req high -> stays FETCH until req low, then high again re-enters DRAIN.
- i_ld_req and ex flush same cycle in FETCH -> o_hold_flag=10 that cycle, 01 next (DRAIN).
